// File: rtl/alu_disp_pkg.sv
// rtl/alu_disp_pkg.sv - shared types and constants for the ALU result display
package alu_disp_pkg;

    // Scan FSM: two lit slots separated by single blanking cycles.
    typedef enum logic [1:0] {
        SHOW0 = 2'd0,
        GAP0  = 2'd1,
        SHOW1 = 2'd2,
        GAP1  = 2'd3
    } disp_state_e;

    // Op encoding shared with the ALU top.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } alu_op_e;

    typedef struct packed {
        logic [2:0] data;
        logic       cb;
        alu_op_e    op;
    } alu_result_t;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Digit codes fed to seg7_decode: 0..9 are numerals.
    localparam logic [3:0] CODE_MINUS = 4'd10;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    // Right digit: magnitude. A negative sub result is shown negated (1..4).
    function automatic logic [3:0] digit0_code(input alu_result_t r);
        logic [2:0] mag;
        if (r.op == OP_SUB && r.data[2]) begin
            mag = ~r.data + 3'd1;
        end else begin
            mag = r.data;
        end
        return {1'b0, mag};
    endfunction

    // Left digit: sign only; blank unless a negative sub result.
    function automatic logic [3:0] digit1_code(input alu_result_t r);
        if (r.op == OP_SUB && r.data[2]) begin
            return CODE_MINUS;
        end
        return CODE_BLANK;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - digit code to active-high seven-segment pattern
//
// Ports:
//   code : 4-bit digit code (0-9, CODE_MINUS, anything else is blank)
//   seg  : 7-bit active-high pattern {g,f,e,d,c,b,a}
module seg7_decode
    import alu_disp_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:       seg = SEG_0;
            4'd1:       seg = SEG_1;
            4'd2:       seg = SEG_2;
            4'd3:       seg = SEG_3;
            4'd4:       seg = SEG_4;
            4'd5:       seg = SEG_5;
            4'd6:       seg = SEG_6;
            4'd7:       seg = SEG_7;
            4'd8:       seg = SEG_8;
            4'd9:       seg = SEG_9;
            CODE_MINUS: seg = SEG_MINUS;
            default:    seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/alu_result_display.sv
// rtl/alu_result_display.sv - captures ALU results and drives a 2-digit muxed 7-seg display
//
// Ports:
//   clk, rst           : clock (rising edge), asynchronous active-low reset
//   res_valid          : single-cycle result strobe
//   res_data/cb/op     : result value, carry/borrow flag, op (0 add, 1 sub)
//   res_ack            : one-cycle pulse the cycle after each capture
//   seg, dp, an        : registered display pins, polarity set by SEG_ACTIVE_LOW
module alu_result_display
    import alu_disp_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       res_valid,
    input  logic [2:0] res_data,
    input  logic       res_cb,
    input  logic       res_op,
    output logic       res_ack,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] an
);

    localparam int               CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]       SEG_OFF   = {7{SEG_ACTIVE_LOW}};
    localparam logic [1:0]       AN_OFF    = {2{SEG_ACTIVE_LOW}};

    disp_state_e      state, state_next;
    logic [CNT_W-1:0] slot_cnt, slot_next;

    alu_result_t shadow;
    logic        have_result;
    alu_result_t disp;
    logic        disp_valid;

    alu_result_t disp_nx;
    logic        disp_valid_nx;
    logic [3:0]  code;
    logic [6:0]  seg_pat;
    logic [6:0]  seg_d;
    logic        dp_d;
    logic [1:0]  an_d;

    // Capture side: no back-pressure, last strobe wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow      <= '0;
            have_result <= 1'b0;
            res_ack     <= 1'b0;
        end else begin
            res_ack <= res_valid;
            if (res_valid) begin
                shadow      <= '{data: res_data, cb: res_cb, op: alu_op_e'(res_op)};
                have_result <= 1'b1;
            end
        end
    end

    // Display register only changes at frame start so a frame never mixes
    // two results. GAP1 is always followed by SHOW0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp       <= '0;
            disp_valid <= 1'b0;
        end else if (state == GAP1) begin
            disp       <= shadow;
            disp_valid <= have_result;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= GAP1;
            slot_cnt <= '0;
        end else begin
            state    <= state_next;
            slot_cnt <= slot_next;
        end
    end

    // FSM next state; slot counter wraps to 0 on every state change.
    always_comb begin
        state_next = state;
        slot_next  = '0;
        case (state)
            SHOW0: begin
                if (slot_cnt == SLOT_LAST) state_next = GAP0;
                else                       slot_next  = slot_cnt + CNT_W'(1);
            end
            GAP0:  state_next = SHOW1;
            SHOW1: begin
                if (slot_cnt == SLOT_LAST) state_next = GAP1;
                else                       slot_next  = slot_cnt + CNT_W'(1);
            end
            GAP1:    state_next = SHOW0;
            default: state_next = GAP1;
        endcase
    end

    // Output values are derived from the upcoming state and display contents,
    // then registered, so seg/dp/an all switch on the same edge as the state.
    always_comb begin
        disp_nx       = (state == GAP1) ? shadow      : disp;
        disp_valid_nx = (state == GAP1) ? have_result : disp_valid;
        code          = CODE_BLANK;
        an_d          = 2'b00;
        dp_d          = 1'b0;
        case (state_next)
            SHOW0: begin
                an_d = 2'b01;
                code = digit0_code(disp_nx);
                dp_d = disp_valid_nx & disp_nx.cb;
            end
            SHOW1: begin
                an_d = 2'b10;
                code = digit1_code(disp_nx);
            end
            default: begin
                an_d = 2'b00;
            end
        endcase
        seg_d = disp_valid_nx ? seg_pat : SEG_BLANK;
    end

    seg7_decode u_seg7_decode (
        .code (code),
        .seg  (seg_pat)
    );

    // Pin registers; polarity applied here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg <= SEG_OFF;
            dp  <= SEG_ACTIVE_LOW;
            an  <= AN_OFF;
        end else begin
            seg <= seg_d ^ SEG_OFF;
            dp  <= dp_d ^ SEG_ACTIVE_LOW;
            an  <= an_d ^ AN_OFF;
        end
    end

endmodule

// File: tb/tb_alu_result_display.sv
// tb/tb_alu_result_display.sv - directed self-checking bench for alu_result_display
module tb_alu_result_display;

    logic       clk;
    logic       rst;
    logic       res_valid;
    logic [2:0] res_data;
    logic       res_cb;
    logic       res_op;
    logic       res_ack;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] an;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected active-low pin patterns, worked out by hand.
    localparam logic [6:0] SEG_OFF_L   = 7'h7F;
    localparam logic [6:0] SEG_1_L     = 7'h79;
    localparam logic [6:0] SEG_3_L     = 7'h30;
    localparam logic [6:0] SEG_5_L     = 7'h12;
    localparam logic [6:0] SEG_6_L     = 7'h02;
    localparam logic [6:0] SEG_MINUS_L = 7'h3F;

    alu_result_display #(
        .REFRESH_DIV    (4),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_cb    (res_cb),
        .res_op    (res_op),
        .res_ack   (res_ack),
        .seg       (seg),
        .dp        (dp),
        .an        (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Advance until an matches, bounded; an expired bound shows up as a failed check.
    task automatic wait_an(input logic [1:0] want, input string tag);
        int n;
        n = 0;
        while (an !== want && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, 8'(an), 8'(want));
    endtask

    task automatic strobe(input logic [2:0] d, input logic cb, input logic op, input string tag);
        res_valid = 1'b1;
        res_data  = d;
        res_cb    = cb;
        res_op    = op;
        step();
        res_valid = 1'b0;
        check({tag, "_ack"}, 8'(res_ack), 8'd1);
        step();
        check({tag, "_ack_clr"}, 8'(res_ack), 8'd0);
    endtask

    initial begin
        int         n;
        logic [1:0] exp_an;

        rst       = 1'b0;
        res_valid = 1'b0;
        res_data  = 3'd0;
        res_cb    = 1'b0;
        res_op    = 1'b0;
        repeat (3) step();

        check("rst_seg", 8'(seg), 8'(SEG_OFF_L));
        check("rst_an", 8'(an), 8'h3);
        check("rst_dp", 8'(dp), 8'd1);
        check("rst_ack", 8'(res_ack), 8'd0);

        // Idle scan: 4 cycles lit, 1 gap, 4 lit, 1 gap.
        rst = 1'b1;
        check("idle_first_gap", 8'(an), 8'h3);
        for (int i = 0; i < 40; i++) begin
            step();
            case (i % 10)
                0, 1, 2, 3:    exp_an = 2'b10;
                5, 6, 7, 8:    exp_an = 2'b01;
                default:       exp_an = 2'b11;
            endcase
            check($sformatf("idle_an_%0d", i), 8'(an), 8'(exp_an));
            check($sformatf("idle_seg_%0d", i), 8'(seg), 8'(SEG_OFF_L));
            check($sformatf("idle_ack_%0d", i), 8'(res_ack), 8'd0);
        end

        // Add 5, no carry.
        step();
        strobe(3'b101, 1'b0, 1'b0, "add5");
        wait_an(2'b01, "add5_wait_s1");
        wait_an(2'b10, "add5_wait_s0");
        check("add5_seg0", 8'(seg), 8'(SEG_5_L));
        check("add5_dp0", 8'(dp), 8'd1);
        wait_an(2'b01, "add5_wait_s1b");
        check("add5_seg1", 8'(seg), 8'(SEG_OFF_L));

        // Sub 3'b111 (-1) with borrow.
        strobe(3'b111, 1'b1, 1'b1, "sub7");
        wait_an(2'b01, "sub7_wait_s1");
        wait_an(2'b10, "sub7_wait_s0");
        check("sub7_seg0", 8'(seg), 8'(SEG_1_L));
        check("sub7_dp0", 8'(dp), 8'd0);
        wait_an(2'b01, "sub7_wait_s1b");
        check("sub7_seg1", 8'(seg), 8'(SEG_MINUS_L));
        check("sub7_dp1", 8'(dp), 8'd1);

        // Back-to-back strobes mid-SHOW1: add 2 then add 6.
        res_valid = 1'b1;
        res_data  = 3'd2;
        res_cb    = 1'b0;
        res_op    = 1'b0;
        step();
        check("b2b_ack1", 8'(res_ack), 8'd1);
        res_data = 3'd6;
        step();
        check("b2b_ack2", 8'(res_ack), 8'd1);
        res_valid = 1'b0;
        check("b2b_old_frame", 8'(seg), 8'(SEG_MINUS_L));
        step();
        check("b2b_ack_clr", 8'(res_ack), 8'd0);
        wait_an(2'b10, "b2b_wait_s0");
        check("b2b_seg0", 8'(seg), 8'(SEG_6_L));
        check("b2b_dp0", 8'(dp), 8'd1);
        wait_an(2'b01, "b2b_wait_s1");
        check("b2b_seg1", 8'(seg), 8'(SEG_OFF_L));

        // Strobe exactly on the GAP1 -> SHOW0 edge: add 3 with carry.
        wait_an(2'b11, "edge_wait_gap1");
        res_valid = 1'b1;
        res_data  = 3'd3;
        res_cb    = 1'b1;
        res_op    = 1'b0;
        step();
        res_valid = 1'b0;
        check("edge_ack", 8'(res_ack), 8'd1);
        check("edge_an", 8'(an), 8'h2);
        check("edge_still_old", 8'(seg), 8'(SEG_6_L));
        n = 1;
        while (!(an === 2'b10 && seg === SEG_3_L) && n < 40) begin
            step();
            n++;
        end
        check("edge_latency_bound", 8'(n <= 15), 8'd1);
        check("edge_seg", 8'(seg), 8'(SEG_3_L));
        check("edge_dp", 8'(dp), 8'd0);

        // Asynchronous reset mid-SHOW0.
        #2;
        rst = 1'b0;
        #1;
        check("arst_seg", 8'(seg), 8'(SEG_OFF_L));
        check("arst_an", 8'(an), 8'h3);
        check("arst_dp", 8'(dp), 8'd1);
        step();
        step();
        check("arst_hold_an", 8'(an), 8'h3);
        check("arst_hold_ack", 8'(res_ack), 8'd0);
        rst = 1'b1;
        check("rel_gap_an", 8'(an), 8'h3);
        step();
        check("rel_show0_an", 8'(an), 8'h2);
        check("rel_show0_seg", 8'(seg), 8'(SEG_OFF_L));
        check("rel_show0_dp", 8'(dp), 8'd1);
        wait_an(2'b01, "rel_wait_s1");
        check("rel_show1_seg", 8'(seg), 8'(SEG_OFF_L));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_result_display.md
Name: alu_result_display

Overview:
- Consumer end of the 2-bit ALU result interface: captures each result strobe (3-bit value, carry/borrow flag, op) and drives a 2-digit multiplexed seven-segment display.
- Add results display as unsigned 0..7. Sub results display as sign plus magnitude; the sign goes on digit 1.
- Sits between the ALU top and the board display pins; replaces raw LED output.

Parameters:
- REFRESH_DIV, 50000, number of clk cycles each digit is lit per scan slot; legal range >= 2.
- SEG_ACTIVE_LOW, 1, 1 = seg/dp/an pins are driven active-low; 0 = active-high.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset; assertion clears all state immediately.
- res_valid  input  1  single-cycle strobe; the res_* inputs are valid in this cycle.
- res_data  input  3  ALU result. Unsigned for add; 3-bit two's complement for sub.
- res_cb  input  1  carry (add) or borrow (sub) flag.
- res_op  input  1  0 = add, 1 = sub.
- res_ack  output  1  registered one-cycle pulse, the cycle after a res_valid capture.
- seg  output  7  segment pattern {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW.
- dp  output  1  decimal point; lit on digit 0 when the displayed result has cb = 1.
- an  output  2  digit enables, one-hot when lit; an[0] = right digit, an[1] = left digit.

Behaviour:
- Reset values (all pins at their inactive level; SEG_ACTIVE_LOW = 1 means all 1s):
  - seg, dp and an all inactive; res_ack = 0.
  - Shadow and display registers = 0; have_result = 0; FSM = GAP1; slot counter = 0.
- Capture:
  - Every res_valid is accepted; there is no back-pressure. {res_data, res_cb, res_op} is written into the shadow register on that edge.
  - res_ack is high in the following cycle.
  - Back-to-back res_valid strobes: each is captured and each is acked; the last one wins.
  - The first capture sets have_result = 1.
- FSM states: SHOW0 -> GAP0 -> SHOW1 -> GAP1 -> SHOW0, repeating.
  - SHOW states last exactly REFRESH_DIV cycles, counted by the slot counter 0..REFRESH_DIV-1, which wraps to 0 on each state change.
  - GAP states last exactly 1 cycle, with every an inactive (anti-ghosting).
- Frame coherency:
  - The display register loads from the shadow register only on the GAP1 -> SHOW0 transition, so a scan frame never mixes two results.
  - Capture-to-display latency is at most 2*REFRESH_DIV + 2 cycles.
  - A res_valid that coincides with the GAP1 -> SHOW0 edge is not shown in that frame; it appears in the next frame.
- Digit content:
  - Add: digit 0 shows res_data as 0..7 and digit 1 is blank.
  - Sub: if res_data[2] = 1, digit 1 shows '-' (g only) and digit 0 shows the magnitude, i.e. the two's-complement negation, 1..4. If res_data[2] = 0, digit 1 is blank and digit 0 shows 0..3.
  - Example: sub with 3'b100 displays "-4".
  - dp follows the display-register cb and is lit only during SHOW0.
- While have_result = 0: scanning runs normally, but seg and dp stay inactive.
- Outputs are registered. seg, dp and an change together on the clock edge of a state change: no glitches and no skew between them.
- Reset asserted mid-frame: outputs go inactive asynchronously. After release, the FSM spends 1 cycle in GAP1, then enters SHOW0 and loads the display register from the (now zero) shadow register.

Decomposition:
- Shared package alu_disp_pkg:
  - FSM state encoding (SHOW0, GAP0, SHOW1, GAP1).
  - Segment constants SEG_0..SEG_9, SEG_MINUS, SEG_BLANK.
  - Op encodings OP_ADD = 0, OP_SUB = 1, shared with the ALU top.
- One sub-module, seg7_decode: combinational; 4-bit code (0-9, minus, blank) -> 7-bit active-high pattern.
- SEG_ACTIVE_LOW inversion is applied in the parent on the output registers.

Test Plan (REFRESH_DIV = 4, SEG_ACTIVE_LOW = 1):
- Reset then idle 40 cycles:
  - an toggles through 2'b10 / 2'b11 (gap) / 2'b01 / 2'b11; each lit slot lasts 4 cycles and each gap 1 cycle.
  - seg = 7'h7F throughout; res_ack = 0.
- res_valid with add, res_data = 3'b101, cb = 0:
  - res_ack = 1 exactly one cycle later.
  - From the next SHOW0: seg = ~SEG_5 with an = 2'b10; seg = 7'h7F (blank) during SHOW1; dp = 1 (off).
- Sub, res_data = 3'b111, cb = 1:
  - SHOW0: seg = ~SEG_1, dp = 0 (lit).
  - SHOW1: seg = ~SEG_MINUS = 7'b0111111.
- Two strobes mid-SHOW1 (add 2, then add 6 on the next cycle):
  - Two res_ack pulses.
  - The current frame still shows the old value; the next frame shows 6; 2 never appears.
- res_valid on the GAP1 -> SHOW0 edge: the value appears one frame later, within 2*4 + 2 + 5 cycles of the strobe.
- Drive rst low mid-SHOW0 with a result displayed:
  - seg, an and dp go inactive with no clock edge.
  - After release: 1 gap cycle, then SHOW0 with blank seg, because have_result = 0.
